// File: rtl/ecpri_pkg.sv
// Shared definitions for the eCPRI transmit path: segment codes, header sizes,
// response kinds and message types used by the tx byte builder.
package ecpri_pkg;

  localparam int ADDR_LEN      = 12;
  localparam int VLAN_LEN      = 4;
  localparam int ETYPE_LEN     = 2;
  localparam int IP_HDR_LEN    = 20;
  localparam int UDP_HDR_LEN   = 8;
  localparam int ECPRI_HDR_LEN = 4;

  typedef enum logic [2:0] {
    SEG_ADDR    = 3'd0,
    SEG_VLAN    = 3'd1,
    SEG_ETYPE   = 3'd2,
    SEG_IP      = 3'd3,
    SEG_UDP     = 3'd4,
    SEG_ECPRI   = 3'd5,
    SEG_PAYLOAD = 3'd6
  } seg_e;

  localparam logic RESP_WR = 1'b0;
  localparam logic RESP_RD = 1'b1;

  localparam logic [7:0] ECPRI_MSG_IQ_DATA = 8'h00;
  localparam logic [7:0] ECPRI_MSG_RT_CTRL = 8'h02;
  localparam logic [7:0] ECPRI_MSG_RMA     = 8'h04;

  // Zero-extends a payload length and adds a fixed header size.
  function automatic logic [15:0] add_hdr(input logic [15:0] len, input int hdr);
    return len + 16'(hdr);
  endfunction

endpackage

// File: rtl/ecpri_rr_arb2.sv
// Two-input round-robin arbiter; input 0 is write response, input 1 is read response.
module ecpri_rr_arb2
  import ecpri_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o = 2'b00;
    if (grant_en_i) begin
      if (&req_i) gnt_o = (last_q == RESP_RD) ? 2'b01 : 2'b10;
      else        gnt_o = req_i;
    end
    last_d = last_q;
    if (|gnt_o) last_d = gnt_o[1];
  end

  // Reset to "read granted last" so a write wins the first tie.
  always_ff @(posedge clk_i) begin
    if (reset_i) last_q <= RESP_RD;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/ecpri_tx_ctrl.sv
// eCPRI transmit sequencer: arbitrates write/read responses and steps the byte
// builder through each frame segment under tx_ready backpressure.
//   state   | meaning
//   IDLE    | waiting for a request, arbitration active
//   ADDR    | MAC dst+src bytes
//   VLAN    | VLAN tag bytes
//   ETYPE   | ethertype bytes
//   IP      | IPv4 header bytes
//   UDP     | UDP header bytes
//   ECPRI   | eCPRI common header bytes
//   PAYLOAD | payload bytes
//   IFG     | inter-frame gap countdown
module ecpri_tx_ctrl
  import ecpri_pkg::*;
#(
  parameter int LEN_W       = 11,
  parameter int MAX_PAYLOAD = 1024,
  parameter int IFG_CYCLES  = 12
) (
  input  logic             inp_clk,
  input  logic             reset,
  input  logic             wr_resp_req,
  input  logic [LEN_W-1:0] wr_resp_len,
  output logic             wr_resp_ack,
  input  logic             rd_resp_req,
  input  logic [LEN_W-1:0] rd_resp_len,
  output logic             rd_resp_ack,
  input  logic             tx_ready,
  output logic [2:0]       seg_sel,
  output logic [LEN_W-1:0] seg_idx,
  output logic             byte_en,
  output logic             sof,
  output logic             eof,
  output logic             resp_kind,
  output logic [15:0]      ecpri_payload_size,
  output logic [15:0]      udp_len,
  output logic [15:0]      ip_total_len,
  output logic             busy,
  output logic             len_err
);

  localparam int IFG_W = $clog2(IFG_CYCLES + 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_VLAN, ST_ETYPE, ST_IP, ST_UDP, ST_ECPRI, ST_PAYLOAD, ST_IFG
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d, len_q, len_d;
  logic [IFG_W-1:0] ifg_q, ifg_d;
  logic             wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
  logic             len_err_q, len_err_d, kind_q, kind_d;
  logic [15:0]      pl_q, pl_d, udp_q, udp_d, ip_q, ip_d;

  logic [1:0]       gnt;
  logic [LEN_W-1:0] sel_len, last_idx;
  logic             in_frame, seg_done, len_bad;

  ecpri_rr_arb2 u_arb (
    .clk_i      (inp_clk),
    .reset_i    (reset),
    .req_i      ({rd_resp_req, wr_resp_req}),
    .grant_en_i (state_q == ST_IDLE),
    .gnt_o      (gnt)
  );

  assign in_frame = state_q inside {ST_ADDR, ST_VLAN, ST_ETYPE, ST_IP, ST_UDP, ST_ECPRI, ST_PAYLOAD};
  assign byte_en  = in_frame & tx_ready;
  assign sel_len  = gnt[1] ? rd_resp_len : wr_resp_len;
  assign len_bad  = 32'(sel_len) > 32'(MAX_PAYLOAD);

  always_comb begin
    last_idx = '0;
    seg_sel  = SEG_ADDR;
    unique case (state_q)
      ST_ADDR:    begin last_idx = LEN_W'(ADDR_LEN - 1);      seg_sel = SEG_ADDR;    end
      ST_VLAN:    begin last_idx = LEN_W'(VLAN_LEN - 1);      seg_sel = SEG_VLAN;    end
      ST_ETYPE:   begin last_idx = LEN_W'(ETYPE_LEN - 1);     seg_sel = SEG_ETYPE;   end
      ST_IP:      begin last_idx = LEN_W'(IP_HDR_LEN - 1);    seg_sel = SEG_IP;      end
      ST_UDP:     begin last_idx = LEN_W'(UDP_HDR_LEN - 1);   seg_sel = SEG_UDP;     end
      ST_ECPRI:   begin last_idx = LEN_W'(ECPRI_HDR_LEN - 1); seg_sel = SEG_ECPRI;   end
      ST_PAYLOAD: begin last_idx = len_q - 1'b1;              seg_sel = SEG_PAYLOAD; end
      default:    begin last_idx = '0;                        seg_sel = SEG_ADDR;    end
    endcase
  end

  assign seg_done = byte_en && (idx_q == last_idx);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    ifg_d     = ifg_q;
    wr_ack_d  = 1'b0;
    rd_ack_d  = 1'b0;
    len_err_d = 1'b0;
    kind_d    = kind_q;
    pl_d      = pl_q;
    udp_d     = udp_q;
    ip_d      = ip_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|gnt) begin
          wr_ack_d = gnt[0];
          rd_ack_d = gnt[1];
          if (len_bad) begin
            len_err_d = 1'b1;
            state_d   = ST_IFG;
            ifg_d     = IFG_W'(IFG_CYCLES - 1);
          end else begin
            state_d = ST_ADDR;
            idx_d   = '0;
            len_d   = sel_len;
            kind_d  = gnt[1] ? RESP_RD : RESP_WR;
            pl_d    = 16'(sel_len);
            udp_d   = add_hdr(16'(sel_len), UDP_HDR_LEN + ECPRI_HDR_LEN);
            ip_d    = add_hdr(16'(sel_len), IP_HDR_LEN + UDP_HDR_LEN + ECPRI_HDR_LEN);
          end
        end
      end
      ST_IFG: begin
        if (ifg_q == '0) state_d = ST_IDLE;
        else             ifg_d   = ifg_q - 1'b1;
      end
      default: begin
        if (seg_done) begin
          idx_d = '0;
          unique case (state_q)
            ST_ADDR:  state_d = ST_VLAN;
            ST_VLAN:  state_d = ST_ETYPE;
            ST_ETYPE: state_d = ST_IP;
            ST_IP:    state_d = ST_UDP;
            ST_UDP:   state_d = ST_ECPRI;
            ST_ECPRI: state_d = (len_q == '0) ? ST_IFG : ST_PAYLOAD;
            default:  state_d = ST_IFG;
          endcase
          if (state_d == ST_IFG) ifg_d = IFG_W'(IFG_CYCLES - 1);
        end else if (byte_en) begin
          idx_d = idx_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge inp_clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      ifg_q     <= '0;
      wr_ack_q  <= 1'b0;
      rd_ack_q  <= 1'b0;
      len_err_q <= 1'b0;
      kind_q    <= 1'b0;
      pl_q      <= '0;
      udp_q     <= '0;
      ip_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      ifg_q     <= ifg_d;
      wr_ack_q  <= wr_ack_d;
      rd_ack_q  <= rd_ack_d;
      len_err_q <= len_err_d;
      kind_q    <= kind_d;
      pl_q      <= pl_d;
      udp_q     <= udp_d;
      ip_q      <= ip_d;
    end
  end

  // With a zero-length payload the frame ends on the last eCPRI header byte.
  assign eof = ((state_q == ST_PAYLOAD) || (state_q == ST_ECPRI && len_q == '0)) &&
               (idx_q == last_idx);
  assign sof                = (state_q == ST_ADDR) && (idx_q == '0);
  assign seg_idx            = idx_q;
  assign busy               = (state_q != ST_IDLE);
  assign wr_resp_ack        = wr_ack_q;
  assign rd_resp_ack        = rd_ack_q;
  assign len_err            = len_err_q;
  assign resp_kind          = kind_q;
  assign ecpri_payload_size = pl_q;
  assign udp_len            = udp_q;
  assign ip_total_len       = ip_q;

endmodule

// File: tb/tb_ecpri_tx_ctrl.sv
// Scoreboard bench for ecpri_tx_ctrl: stimulus pushes expected grants, a negedge
// monitor pops them on ack and follows each frame byte by byte.
module tb_ecpri_tx_ctrl;

  logic        inp_clk;
  logic        reset;
  logic        wr_resp_req, rd_resp_req;
  logic [10:0] wr_resp_len, rd_resp_len;
  logic        wr_resp_ack, rd_resp_ack;
  logic        tx_ready;
  logic [2:0]  seg_sel;
  logic [10:0] seg_idx;
  logic        byte_en, sof, eof, resp_kind, busy, len_err;
  logic [15:0] ecpri_payload_size, udp_len, ip_total_len;

  ecpri_tx_ctrl dut (
    .inp_clk(inp_clk), .reset(reset),
    .wr_resp_req(wr_resp_req), .wr_resp_len(wr_resp_len), .wr_resp_ack(wr_resp_ack),
    .rd_resp_req(rd_resp_req), .rd_resp_len(rd_resp_len), .rd_resp_ack(rd_resp_ack),
    .tx_ready(tx_ready), .seg_sel(seg_sel), .seg_idx(seg_idx), .byte_en(byte_en),
    .sof(sof), .eof(eof), .resp_kind(resp_kind),
    .ecpri_payload_size(ecpri_payload_size), .udp_len(udp_len), .ip_total_len(ip_total_len),
    .busy(busy), .len_err(len_err)
  );

  initial inp_clk = 1'b0;
  always #5 inp_clk = ~inp_clk;

  typedef struct {int kind; int len; int err; int gap;} exp_t;
  exp_t sb_q[$];

  int cyc = 0;
  always @(posedge inp_clk) cyc <= cyc + 1;

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic summary();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
  endtask

  // Expected (segment, index) of byte number p in a frame with payload len.
  function automatic void exp_at(input int len, input int p, output int seg, output int idx);
    int lens[7];
    lens[0] = 12; lens[1] = 4; lens[2] = 2; lens[3] = 20;
    lens[4] = 8;  lens[5] = 4; lens[6] = len;
    seg = -1;
    idx = p;
    for (int s = 0; s < 7; s++) begin
      if (idx < lens[s]) begin
        seg = s;
        return;
      end
      idx -= lens[s];
    end
  endfunction

  // Monitor state
  int  active = 0, pos = 0, cur_len = 0, ifg_left = 0, idle_chk = 0;
  int  last_end = 0, stall = 0, rst_prev = 0;
  int  prev_pl = 0, prev_udp = 0, prev_ip = 0;

  always @(negedge inp_clk) begin
    exp_t e;
    int   es, ei;
    if (busy || sb_q.size() != 0) stall++;
    else stall = 0;
    if (stall > 3000) begin
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: stalled %0d cycles, required below 3000", stall);
      summary();
      $finish;
    end
    if (rst_prev != 0)
      chk("reset_outputs", int'(|{wr_resp_ack, rd_resp_ack, byte_en, sof, eof, resp_kind, busy,
          len_err, seg_sel, seg_idx, ecpri_payload_size, udp_len, ip_total_len}), 0);
    rst_prev = int'(reset);
    if (reset) begin
      active = 0; ifg_left = 0; idle_chk = 0; last_end = cyc;
      prev_pl = 0; prev_udp = 0; prev_ip = 0;
    end else begin
      if (wr_resp_ack || rd_resp_ack) begin
        if (sb_q.size() == 0) begin
          chk("ack_unexpected", int'(wr_resp_ack | rd_resp_ack), 0);
        end else begin
          e = sb_q.pop_front();
          chk("ack_onehot", int'(wr_resp_ack & rd_resp_ack), 0);
          chk("ack_kind", int'(rd_resp_ack), e.kind);
          chk("len_err", int'(len_err), e.err);
          if (e.gap != 0) chk("grant_gap", cyc - last_end, e.gap);
          if (e.err != 0) begin
            chk("err_keeps_payload_size", int'(ecpri_payload_size), prev_pl);
            chk("err_keeps_udp_len", int'(udp_len), prev_udp);
            chk("err_keeps_ip_len", int'(ip_total_len), prev_ip);
            ifg_left = 12;
            last_end = cyc;
          end else begin
            chk("resp_kind", int'(resp_kind), e.kind);
            chk("ecpri_payload_size", int'(ecpri_payload_size), e.len);
            chk("udp_len", int'(udp_len), e.len + 12);
            chk("ip_total_len", int'(ip_total_len), e.len + 32);
            prev_pl = e.len; prev_udp = e.len + 12; prev_ip = e.len + 32;
            cur_len = e.len;
            pos = 0;
            active = 1;
          end
        end
      end else begin
        chk("len_err_stray", int'(len_err), 0);
      end
      if (idle_chk != 0) begin
        chk("idle_after_ifg", int'(busy), 0);
        idle_chk = 0;
      end
      if (ifg_left > 0) begin
        chk("busy_in_ifg", int'(busy), 1);
        ifg_left--;
        if (ifg_left == 0) idle_chk = 1;
      end
      if (active != 0) begin
        exp_at(cur_len, pos, es, ei);
        chk("seg_sel", int'(seg_sel), es);
        chk("seg_idx", int'(seg_idx), ei);
        chk("sof", int'(sof), int'(pos == 0));
        chk("eof", int'(eof), int'(pos == 49 + cur_len));
        chk("busy_in_frame", int'(busy), 1);
        if (byte_en) begin
          pos++;
          if (pos == 50 + cur_len) begin
            active = 0;
            last_end = cyc;
            ifg_left = 12;
          end
        end
      end else begin
        chk("byte_en_stray", int'(byte_en), 0);
      end
    end
  end

  // Stimulus side
  int ready_mode = 0;
  int model_last = 1;

  task automatic step();
    @(posedge inp_clk);
    #1;
    if (wr_resp_ack) wr_resp_req = 1'b0;
    if (rd_resp_ack) rd_resp_req = 1'b0;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic run_until_idle();
    int n = 0;
    do begin
      step();
      n++;
    end while (!(n >= 2 && !wr_resp_req && !rd_resp_req && sb_q.size() == 0 && !busy &&
                 active == 0 && ifg_left == 0 && idle_chk == 0));
  endtask

  function automatic int is_err(input int len);
    return int'(len > 1024);
  endfunction

  task automatic issue_one(input int kind, input int len);
    exp_t e;
    e.kind = kind; e.len = len; e.err = is_err(len); e.gap = 0;
    sb_q.push_back(e);
    model_last = kind;
    if (kind == 0) begin wr_resp_len = 11'(len); wr_resp_req = 1'b1; end
    else           begin rd_resp_len = 11'(len); rd_resp_req = 1'b1; end
  endtask

  task automatic issue_both(input int wlen, input int rlen);
    exp_t a, b;
    int   w;
    w = (model_last == 1) ? 0 : 1;
    a.kind = w;     a.len = (w == 0) ? wlen : rlen; a.err = is_err(a.len); a.gap = 0;
    b.kind = 1 - w; b.len = (w == 0) ? rlen : wlen; b.err = is_err(b.len);
    b.gap = (a.err != 0) ? 13 : 14;
    sb_q.push_back(a);
    sb_q.push_back(b);
    model_last = 1 - w;
    wr_resp_len = 11'(wlen); rd_resp_len = 11'(rlen);
    wr_resp_req = 1'b1;      rd_resp_req = 1'b1;
  endtask

  function automatic int rnd_len();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return int'($urandom_range(1025, 2047));
    if (r == 1) return 0;
    return int'($urandom_range(1, 60));
  endfunction

  initial begin
    exp_t e;
    int   n;
    reset = 1'b1; tx_ready = 1'b0;
    wr_resp_req = 1'b0; rd_resp_req = 1'b0;
    wr_resp_len = '0;   rd_resp_len = '0;
    repeat (3) @(posedge inp_clk);
    #1 reset = 1'b0;
    model_last = 1;
    step();

    ready_mode = 0;
    issue_both(4, 16);          run_until_idle();
    issue_one(0, 5);            run_until_idle();
    issue_one(0, 8);            run_until_idle();
    ready_mode = 1;
    issue_one(0, 2);            run_until_idle();
    ready_mode = 0;
    issue_one(1, 0);            run_until_idle();
    issue_one(0, 1025);         run_until_idle();
    issue_one(0, 1024);         run_until_idle();

    // Reset in the middle of the IP header with a read request pending.
    issue_one(0, 30);
    n = 0;
    do begin step(); n++; end while (wr_resp_req && n < 50);
    e.kind = 1; e.len = 7; e.err = 0; e.gap = 2;
    sb_q.push_back(e);
    rd_resp_len = 11'd7;
    rd_resp_req = 1'b1;
    n = 0;
    while (!(int'(seg_sel) == 3 && int'(seg_idx) == 5) && n < 300) begin step(); n++; end
    reset = 1'b1;
    step();
    reset = 1'b0;
    model_last = 1;
    run_until_idle();

    ready_mode = 2;
    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 9) < 3) issue_both(rnd_len(), rnd_len());
      else                          issue_one(int'($urandom_range(0, 1)), rnd_len());
      run_until_idle();
    end

    repeat (4) step();
    summary();
    $finish;
  end

endmodule
